// File: rtl/fwd_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_ctrl - operand forwarding and load-use hazard control for a 5-stage pipe.
//
// Keeps a two-entry history (EX slot, MEM slot) of the instructions that left
// decode. From that history it chooses where each ALU operand comes from and
// requests a one-cycle stall when a load in EX feeds the instruction in decode.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   id_valid      decode stage holds a real instruction
//   id_rs1/id_rs2 source register addresses (AW bits)
//   id_imm_b      operand B comes from the immediate
//   id_rd         destination register address (AW bits)
//   id_wen        instruction writes id_rd
//   id_load       instruction is a load
//   freeze        external pipeline hold (both slots keep their contents)
//   flush         kill the instruction entering EX
//   sel_a         operand-A select: 0 regfile, 1 EX result, 2 MEM result
//   sel_b         operand-B select: as sel_a, plus 3 immediate
//   hazard_stall  load-use stall request to fetch/decode
//   stall_cnt     saturating count of stall cycles (CW bits)
// -----------------------------------------------------------------------------
module fwd_ctrl #(
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_imm_b,
    input  logic [AW-1:0] id_rd,
    input  logic          id_wen,
    input  logic          id_load,
    input  logic          freeze,
    input  logic          flush,
    output logic [1:0]    sel_a,
    output logic [1:0]    sel_b,
    output logic          hazard_stall,
    output logic [CW-1:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_IMM = 2'd3;

    // A history slot supplies a source only if it really writes a non-zero
    // register with that address; r0 is hard-wired and never forwarded.
    function automatic logic slot_match(
        input logic          valid,
        input logic          wen,
        input logic [AW-1:0] rd,
        input logic [AW-1:0] rs
    );
        return valid & wen & (rd == rs) & (rd != {AW{1'b0}});
    endfunction

    // EX slot
    logic          ex_valid_r;
    logic [AW-1:0] ex_rd_r;
    logic          ex_wen_r;
    logic          ex_load_r;
    // MEM slot
    logic          mem_valid_r;
    logic [AW-1:0] mem_rd_r;
    logic          mem_wen_r;
    logic          mem_load_r;

    logic [CW-1:0] stall_cnt_r;

    logic ex_match_rs1_s;
    logic ex_match_rs2_s;
    logic mem_match_rs1_s;
    logic mem_match_rs2_s;
    logic hazard_s;

    // Source-versus-slot comparisons; these use only registered state and ID
    // inputs so freeze/flush never reach the select or stall outputs.
    always_comb begin
        ex_match_rs1_s  = slot_match(ex_valid_r,  ex_wen_r,  ex_rd_r,  id_rs1);
        ex_match_rs2_s  = slot_match(ex_valid_r,  ex_wen_r,  ex_rd_r,  id_rs2);
        mem_match_rs1_s = slot_match(mem_valid_r, mem_wen_r, mem_rd_r, id_rs1);
        mem_match_rs2_s = slot_match(mem_valid_r, mem_wen_r, mem_rd_r, id_rs2);
    end

    // Operand selects, EX has priority because it holds the younger value.
    always_comb begin
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        if (ex_match_rs1_s) begin
            sel_a = SEL_EX;
        end else if (mem_match_rs1_s) begin
            sel_a = SEL_MEM;
        end else begin
            sel_a = SEL_RF;
        end
        if (id_imm_b) begin
            sel_b = SEL_IMM;
        end else if (ex_match_rs2_s) begin
            sel_b = SEL_EX;
        end else if (mem_match_rs2_s) begin
            sel_b = SEL_MEM;
        end else begin
            sel_b = SEL_RF;
        end
    end

    // Load-use hazard: a load result is not available until it reaches MEM,
    // so a consumer directly behind it must wait one cycle. An immediate
    // operand B does not read rs2 and therefore cannot cause a stall.
    always_comb begin
        hazard_s = id_valid & ex_load_r &
                   (ex_match_rs1_s | (~id_imm_b & ex_match_rs2_s));
    end

    assign hazard_stall = hazard_s;
    assign stall_cnt    = stall_cnt_r;

    // EX slot update: flush beats freeze beats normal advance; a stall turns
    // the incoming instruction into a bubble while decode holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_rd_r    <= {AW{1'b0}};
            ex_wen_r   <= 1'b0;
            ex_load_r  <= 1'b0;
        end else if (flush) begin
            ex_valid_r <= 1'b0;
            ex_rd_r    <= {AW{1'b0}};
            ex_wen_r   <= 1'b0;
            ex_load_r  <= 1'b0;
        end else if (!freeze) begin
            ex_valid_r <= id_valid & ~hazard_s;
            ex_rd_r    <= id_rd;
            ex_wen_r   <= id_wen;
            ex_load_r  <= id_load;
        end else begin
            ex_valid_r <= ex_valid_r;
            ex_rd_r    <= ex_rd_r;
            ex_wen_r   <= ex_wen_r;
            ex_load_r  <= ex_load_r;
        end
    end

    // MEM slot update: takes the old EX contents unless the pipe is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_r <= 1'b0;
            mem_rd_r    <= {AW{1'b0}};
            mem_wen_r   <= 1'b0;
            mem_load_r  <= 1'b0;
        end else if (!freeze) begin
            mem_valid_r <= ex_valid_r;
            mem_rd_r    <= ex_rd_r;
            mem_wen_r   <= ex_wen_r;
            mem_load_r  <= ex_load_r;
        end else begin
            mem_valid_r <= mem_valid_r;
            mem_rd_r    <= mem_rd_r;
            mem_wen_r   <= mem_wen_r;
            mem_load_r  <= mem_load_r;
        end
    end

    // Stall statistics: frozen cycles are not counted, value sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CW{1'b0}};
        end else if (hazard_s && !freeze && (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_ctrl - directed self-checking bench for fwd_ctrl.
// Each step drives the decode inputs, pushes the expected outputs to a
// scoreboard queue and pops/compares them on the following falling edge.
// A second instance with a 3-bit counter exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_fwd_ctrl;

    typedef struct {
        string       tag;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        h;
        logic [15:0] c;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_imm_b;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_load;
    logic        freeze;
    logic        flush;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        hazard_stall;
    logic [15:0] stall_cnt;
    logic [1:0]  sat_sel_a;
    logic [1:0]  sat_sel_b;
    logic        sat_hazard;
    logic [2:0]  sat_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fwd_ctrl #(.AW(5), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_imm_b(id_imm_b), .id_rd(id_rd), .id_wen(id_wen),
        .id_load(id_load), .freeze(freeze), .flush(flush), .sel_a(sel_a),
        .sel_b(sel_b), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    fwd_ctrl #(.AW(5), .CW(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_imm_b(id_imm_b), .id_rd(id_rd), .id_wen(id_wen),
        .id_load(id_load), .freeze(freeze), .flush(flush), .sel_a(sat_sel_a),
        .sel_b(sat_sel_b), .hazard_stall(sat_hazard), .stall_cnt(sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [1:0] a, input logic [1:0] b,
                        input logic h, input logic [15:0] c);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.h = h; e.c = c;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic [15:0] sat_exp;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            sat_exp = (e.c > 16'd7) ? 16'd7 : e.c;
            cmp({e.tag, ".sel_a"},     {30'd0, sel_a},        {30'd0, e.a});
            cmp({e.tag, ".sel_b"},     {30'd0, sel_b},        {30'd0, e.b});
            cmp({e.tag, ".stall"},     {31'd0, hazard_stall}, {31'd0, e.h});
            cmp({e.tag, ".cnt"},       {16'd0, stall_cnt},    {16'd0, e.c});
            cmp({e.tag, ".sat_cnt"},   {29'd0, sat_cnt},      {16'd0, sat_exp});
            cmp({e.tag, ".sat_stall"}, {31'd0, sat_hazard},   {31'd0, e.h});
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic imm, input logic [4:0] rd, input logic wen,
                         input logic ld, input logic frz, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_imm_b = imm;
        id_rd = rd; id_wen = wen; id_load = ld; freeze = frz; flush = fl;
    endtask

    // one pipeline cycle: inputs already driven, expectation queued,
    // compared on the falling edge, then advance past the rising edge
    task automatic step(input string tag,
                        input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic imm, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic frz, input logic fl,
                        input logic [1:0] ea, input logic [1:0] eb,
                        input logic eh, input logic [15:0] ec);
        drive(v, rs1, rs2, imm, rd, wen, ld, frz, fl);
        push(tag, ea, eb, eh, ec);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] c;
        rst_n = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        push("reset_imm", 2'd0, 2'd3, 1'b0, 16'd0);
        check_now();
        id_imm_b = 1'b0;
        #1;
        push("reset_reg", 2'd0, 2'd0, 1'b0, 16'd0);
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //   tag           v    rs1    rs2    imm   rd     wen   ld    frz   fl    a     b     h     cnt
        // ALU dependency
        step("alu_issue",  1'b1, 5'd0, 5'd0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("alu_ex_fwd", 1'b1, 5'd3, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 16'd0);
        step("alu_mem_fwd",1'b1, 5'd0, 5'd3, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 16'd0);
        // load-use
        step("lu_issue",   1'b1, 5'd0, 5'd0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("lu_stall",   1'b1, 5'd5, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 16'd0);
        step("lu_resolve", 1'b1, 5'd5, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 16'd1);
        // r0 and EX priority
        step("r0_write",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd1);
        step("r0_no_fwd",  1'b1, 5'd0, 5'd0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd1);
        step("r7_second",  1'b1, 5'd0, 5'd7, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 16'd1);
        step("prio_ex",    1'b1, 5'd7, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 16'd1);
        step("r7_mem",     1'b1, 5'd7, 5'd7, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 16'd1);
        // immediate and freeze
        step("ld9_issue",  1'b1, 5'd0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd1);
        step("imm_b",      1'b1, 5'd0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step("frz_hold", 1'b1, 5'd10, 5'd9, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 16'd1);
        end
        step("frz_release",1'b1, 5'd10, 5'd9, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0, 16'd1);
        step("post_frz",   1'b1, 5'd10, 5'd11,1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 16'd1);
        // flush during load-use stall
        step("ld6_issue",  1'b1, 5'd0, 5'd0, 1'b0, 5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd1);
        step("stall_frz",  1'b1, 5'd6, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 16'd1);
        step("stall_flush",1'b1, 5'd6, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 16'd1);
        step("after_flush",1'b1, 5'd6, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 16'd2);
        step("ld8_issue",  1'b1, 5'd0, 5'd0, 1'b0, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd2);
        step("flush_frz",  1'b1, 5'd8, 5'd8, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 16'd2);
        step("ld8_killed", 1'b1, 5'd8, 5'd8, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd2);
        // reset asserted mid-stall
        step("ld4_issue",  1'b1, 5'd0, 5'd0, 1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd2);
        drive(1'b1, 5'd4, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("pre_rst_stall", 2'd1, 2'd3, 1'b1, 16'd2);
        @(negedge clk);
        check_now();
        #1;
        rst_n = 1'b0;
        push("rst_mid", 2'd0, 2'd3, 1'b0, 16'd0);
        #1;
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("after_rst",  1'b1, 5'd4, 5'd0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 16'd0);
        // invalid decode slot never stalls; immediate B hides an rs2 load match
        step("ld5_a",      1'b1, 5'd0, 5'd0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("idle_match", 1'b0, 5'd5, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 16'd0);
        step("ld5_b",      1'b1, 5'd0, 5'd0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("imm_no_stall",1'b1,5'd0, 5'd5, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 16'd0);
        // repeated load-use stalls, small counter saturates at 7
        c = 16'd0;
        for (int i = 0; i < 9; i++) begin
            step("sat_load", 1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, c);
            if (i % 2 == 1) begin
                step("sat_use_rs2", 1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, c);
            end else begin
                step("sat_use_rs1", 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, c);
            end
            c = c + 16'd1;
        end
        step("sat_final",  1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd9);

        cmp("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter CW, default 16, stall-counter width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 id_valid  input  1  decode stage holds a real instruction.
REQ-007 id_rs1, id_rs2  input  AW each  source register addresses.
REQ-008 id_imm_b  input  1  operand B comes from the immediate.
REQ-009 id_rd  input  AW  destination register address.
REQ-010 id_wen  input  1  instruction writes id_rd.
REQ-011 id_load  input  1  instruction is a load.
REQ-012 freeze  input  1  external pipeline hold (memory wait).
REQ-013 flush  input  1  kill the instruction entering EX (branch taken).
REQ-014 sel_a  output  2  operand-A 4:1 mux select.
REQ-015 sel_b  output  2  operand-B 4:1 mux select.
REQ-016 hazard_stall  output  1  load-use stall request to fetch/decode.
REQ-017 stall_cnt  output  CW  count of hazard_stall cycles.

Function
REQ-018 Select encoding SHALL be 0 = register file, 1 = EX result, 2 = MEM result, 3 = immediate; sel_a SHALL never be 3.
REQ-019 Block SHALL hold two history slots, EX and MEM, each with: valid, rd, wen, load.
REQ-020 A slot SHALL match source rs only if valid, wen, rd == rs, and rd != 0.
REQ-021 sel_a SHALL be combinational from the slots and ID inputs: 1 if EX matches id_rs1, else 2 if MEM matches, else 0 (EX priority).
REQ-022 sel_b SHALL be 3 when id_imm_b = 1, else the same rule as sel_a applied to id_rs2.
REQ-023 hazard_stall SHALL be 1 when id_valid = 1, the EX slot has load = 1, and EX matches id_rs1 or (id_imm_b = 0 and EX matches id_rs2).
REQ-024 With freeze = 0 and flush = 0, each rising edge: MEM <= EX; EX <= ID fields with valid = id_valid & ~hazard_stall.
REQ-025 hazard_stall = 1 SHALL insert a bubble (valid = 0) into EX while MEM advances, so the stall resolves after exactly one cycle.
REQ-026 freeze = 1 SHALL hold both slots unchanged; sel_a, sel_b and hazard_stall SHALL still be evaluated.
REQ-027 flush = 1 SHALL load EX with a bubble regardless of freeze or hazard_stall; MEM SHALL take old EX if freeze = 0, else hold.
REQ-028 A load in MEM SHALL forward through select 2 with no stall.
REQ-029 stall_cnt SHALL increment on each rising edge with hazard_stall = 1 and freeze = 0, saturating at all-ones.
REQ-030 Outputs SHALL depend only on the current-cycle inputs and registered state; there SHALL be no combinational path from freeze or flush to sel_a, sel_b or hazard_stall.

Reset
REQ-031 rst_n = 0 SHALL immediately clear both slot valid bits, rd, wen and load, and set stall_cnt = 0.
REQ-032 During and after reset, with no valid slots, sel_a = 0 and hazard_stall = 0; sel_b = 3 if id_imm_b = 1, else 0.
REQ-033 Reset asserted mid-stall SHALL drop hazard_stall in the same cycle; first edge after release SHALL behave as from empty.

Verification
REQ-034 ALU dependency: cycle0 issue rd = 3 wen; cycle1 id_rs1 = 3 -> sel_a = 1, hazard_stall = 0; cycle2 id_rs2 = 3 -> sel_b = 2.
REQ-035 Load-use: cycle0 load rd = 5; cycle1 id_rs1 = 5 -> hazard_stall = 1 for 1 cycle, stall_cnt = 1; cycle2 same ID -> sel_a = 2, hazard_stall = 0.
REQ-036 r0 and priority: writes to rd = 0 -> rs1 = 0 gives sel_a = 0; back-to-back writes to rd = 7 -> rs1 = 7 gives sel_a = 1 (EX wins).
REQ-037 Immediate and freeze: id_imm_b = 1 with EX match on rs2 -> sel_b = 3, no stall; freeze = 1 for 3 cycles -> slots unchanged, selects stable.
REQ-038 Flush and reset: flush = 1 during load-use stall -> EX bubble, next-cycle hazard_stall = 0; rst_n pulse mid-sequence -> all selects 0, stall_cnt = 0; stall_cnt forced to saturate stays at 16'hFFFF.
